// File: rtl/timer_cuenta_regresiva.sv
// timer_cuenta_regresiva: BCD hh:mm:ss countdown timer with IDLE/RUN/ALARMA FSM; TIMER_AUTORECARGA_EN enables auto-reload of the preset on expiry.
module timer_cuenta_regresiva (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic       ack_alarma,
  input  logic [7:0] seg_ini,
  input  logic [7:0] min_ini,
  input  logic [7:0] hora_ini,
  output logic [7:0] count_seg_timer,
  output logic [7:0] count_min_timer,
  output logic [7:0] count_hora_timer,
  output logic       alarma,
  output logic       running,
  output logic       load_err
);
  typedef enum logic [1:0] {IDLE, RUN, ALARMA} state_t;
  state_t state, state_n, ack_state;
  logic [23:0] cnt, cnt_n, preset, preset_n, ini, dec, expiry_cnt;
  logic load_err_n, ini_ok;
  function automatic logic [7:0] dec_bcd(input logic [7:0] v);
    return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
  endfunction
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction
  assign ini    = {hora_ini, min_ini, seg_ini};
  assign ini_ok = bcd_ok(seg_ini, 8'h59) && bcd_ok(min_ini, 8'h59) && bcd_ok(hora_ini, 8'h23);
  // Only evaluated while RUN, where the count is never zero, so hours never wrap.
  assign dec = (cnt[7:0] != 8'h00)  ? {cnt[23:8], dec_bcd(cnt[7:0])} :
               (cnt[15:8] != 8'h00) ? {cnt[23:16], dec_bcd(cnt[15:8]), 8'h59} :
                                      {dec_bcd(cnt[23:16]), 8'h59, 8'h59};
`ifdef TIMER_AUTORECARGA_EN
  assign expiry_cnt = preset;
  assign ack_state  = RUN;
`else
  assign expiry_cnt = '0;
  assign ack_state  = IDLE;
`endif
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    preset_n   = preset;
    load_err_n = 1'b0;
    if (load) begin
      if (ini_ok) begin
        cnt_n    = ini;
        preset_n = ini;
        state_n  = IDLE;
      end else load_err_n = 1'b1;
    end else if (state == RUN) begin
      if (stop) state_n = IDLE;
      else if (tick_1hz) begin
        cnt_n   = (dec == '0) ? expiry_cnt : dec;
        state_n = (dec == '0) ? ALARMA : RUN;
      end
    end else if (state == ALARMA) state_n = ack_alarma ? ack_state : ALARMA;
    else if (start && cnt != '0) state_n = RUN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      preset   <= '0;
      alarma   <= 1'b0;
      running  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      preset   <= preset_n;
      alarma   <= state_n == ALARMA;
      running  <= state_n == RUN;
      load_err <= load_err_n;
    end
  end
  assign {count_hora_timer, count_min_timer, count_seg_timer} = cnt;
endmodule

// File: tb/tb_timer_cuenta_regresiva.sv
// tb_timer_cuenta_regresiva: directed self-checking bench for the BCD countdown timer.
module tb_timer_cuenta_regresiva;
`ifdef TIMER_AUTORECARGA_EN
  localparam logic AR = 1'b1;
`else
  localparam logic AR = 1'b0;
`endif
  localparam logic [5:0] R = 6'b100000, L = 6'b010000, S = 6'b001000,
                         P = 6'b000100, A = 6'b000010, T = 6'b000001;
  logic clk = 0, reset = 0, tick_1hz = 0, load = 0, start = 0, stop = 0, ack_alarma = 0;
  logic [7:0] seg_ini = 0, min_ini = 0, hora_ini = 0;
  logic [7:0] cs, cm, ch;
  logic alarma, running, load_err;
  logic [23:0] cnt, exp_cnt;
  int errs = 0, checks = 0;
  assign cnt = {ch, cm, cs};
  always #5 clk = ~clk;
  timer_cuenta_regresiva dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .load(load), .start(start),
    .stop(stop), .ack_alarma(ack_alarma), .seg_ini(seg_ini), .min_ini(min_ini),
    .hora_ini(hora_ini), .count_seg_timer(cs), .count_min_timer(cm),
    .count_hora_timer(ch), .alarma(alarma), .running(running), .load_err(load_err)
  );
  task automatic step(input logic [5:0] c);
    {reset, load, start, stop, ack_alarma, tick_1hz} = c;
    @(posedge clk);
    #1;
    {reset, load, start, stop, ack_alarma, tick_1hz} = 6'b0;
  endtask
  task automatic set_ini(input logic [23:0] v);
    {hora_ini, min_ini, seg_ini} = v;
  endtask
  task automatic test_reset;
    set_ini(24'h123456); step(L); step(S); step(R);
    checks++; if (cnt !== 24'h0) begin errs++; $display("FAIL reset_count got %h want %h", cnt, 24'h0); end
    checks++; if (alarma !== 1'b0) begin errs++; $display("FAIL reset_alarma got %b want 0", alarma); end
    checks++; if (running !== 1'b0) begin errs++; $display("FAIL reset_running got %b want 0", running); end
    checks++; if (load_err !== 1'b0) begin errs++; $display("FAIL reset_load_err got %b want 0", load_err); end
    step(S);
    checks++; if (running !== 1'b0) begin errs++; $display("FAIL start_at_zero got %b want 0", running); end
  endtask
  task automatic test_countdown;
    set_ini(24'h000005); step(L);
    checks++; if (cnt !== 24'h000005) begin errs++; $display("FAIL load5_count got %h want 000005", cnt); end
    step(S);
    checks++; if (running !== 1'b1) begin errs++; $display("FAIL start_running got %b want 1", running); end
    for (int i = 1; i <= 5; i++) begin
      step(T);
      exp_cnt = (i == 5) ? (AR ? 24'h000005 : 24'h0) : 24'(5 - i);
      checks++; if (cnt !== exp_cnt) begin errs++; $display("FAIL tick%0d_count got %h want %h", i, cnt, exp_cnt); end
    end
    checks++; if (alarma !== 1'b1) begin errs++; $display("FAIL expiry_alarma got %b want 1", alarma); end
    checks++; if (running !== 1'b0) begin errs++; $display("FAIL expiry_running got %b want 0", running); end
    step(T); step(S); step(P);
    checks++; if (cnt !== exp_cnt) begin errs++; $display("FAIL alarm_tick_count got %h want %h", cnt, exp_cnt); end
    checks++; if (alarma !== 1'b1) begin errs++; $display("FAIL alarm_start_stop got %b want 1", alarma); end
    step(A);
    checks++; if (alarma !== 1'b0) begin errs++; $display("FAIL ack_alarma got %b want 0", alarma); end
    checks++; if (running !== AR) begin errs++; $display("FAIL ack_running got %b want %b", running, AR); end
  endtask
  task automatic test_borrow;
    set_ini(24'h010000); step(L); step(S); step(T);
    checks++; if (cnt !== 24'h005959) begin errs++; $display("FAIL borrow_hour got %h want 005959", cnt); end
    step(T);
    checks++; if (cnt !== 24'h005958) begin errs++; $display("FAIL borrow_next got %h want 005958", cnt); end
    set_ini(24'h001000); step(L); step(S); step(T);
    checks++; if (cnt !== 24'h000959) begin errs++; $display("FAIL borrow_min_tens got %h want 000959", cnt); end
    set_ini(24'h100000); step(L); step(S); step(T);
    checks++; if (cnt !== 24'h095959) begin errs++; $display("FAIL borrow_hour_tens got %h want 095959", cnt); end
  endtask
  task automatic test_load_err;
    set_ini(24'h00005A); step(L);
    checks++; if (load_err !== 1'b1) begin errs++; $display("FAIL err_seg got %b want 1", load_err); end
    checks++; if (cnt !== 24'h095959) begin errs++; $display("FAIL err_seg_count got %h want 095959", cnt); end
    checks++; if (running !== 1'b1) begin errs++; $display("FAIL err_seg_state got %b want 1", running); end
    step(6'b0);
    checks++; if (load_err !== 1'b0) begin errs++; $display("FAIL err_pulse_width got %b want 0", load_err); end
    set_ini(24'h006000); step(L);
    checks++; if (load_err !== 1'b1) begin errs++; $display("FAIL err_min got %b want 1", load_err); end
    set_ini(24'h240000); step(L);
    checks++; if (load_err !== 1'b1) begin errs++; $display("FAIL err_hora got %b want 1", load_err); end
    set_ini(24'h0A0000); step(L);
    checks++; if (load_err !== 1'b1) begin errs++; $display("FAIL err_nibble got %b want 1", load_err); end
    checks++; if (cnt !== 24'h095959) begin errs++; $display("FAIL err_count_kept got %h want 095959", cnt); end
    set_ini(24'h235959); step(L);
    checks++; if (load_err !== 1'b0) begin errs++; $display("FAIL max_valid_err got %b want 0", load_err); end
    checks++; if (cnt !== 24'h235959) begin errs++; $display("FAIL max_valid_count got %h want 235959", cnt); end
    checks++; if (running !== 1'b0) begin errs++; $display("FAIL load_to_idle got %b want 0", running); end
  endtask
  task automatic test_pause;
    set_ini(24'h000010); step(L); step(S); step(P | T);
    checks++; if (cnt !== 24'h000010) begin errs++; $display("FAIL stop_tick_count got %h want 000010", cnt); end
    checks++; if (running !== 1'b0) begin errs++; $display("FAIL stop_running got %b want 0", running); end
    step(S | T);
    checks++; if (cnt !== 24'h000010) begin errs++; $display("FAIL start_tick_count got %h want 000010", cnt); end
    checks++; if (running !== 1'b1) begin errs++; $display("FAIL resume_running got %b want 1", running); end
    step(T);
    checks++; if (cnt !== 24'h000009) begin errs++; $display("FAIL resume_tick got %h want 000009", cnt); end
    step(P); step(T);
    checks++; if (cnt !== 24'h000009) begin errs++; $display("FAIL idle_tick got %h want 000009", cnt); end
  endtask
  task automatic test_reset_mid;
    set_ini(24'h000003); step(L); step(S); step(R | T);
    checks++; if (cnt !== 24'h0) begin errs++; $display("FAIL reset_run_count got %h want 000000", cnt); end
    checks++; if (running !== 1'b0) begin errs++; $display("FAIL reset_run_running got %b want 0", running); end
    set_ini(24'h000001); step(L); step(S); step(T);
    checks++; if (alarma !== 1'b1) begin errs++; $display("FAIL one_sec_alarma got %b want 1", alarma); end
    step(R);
    checks++; if (alarma !== 1'b0) begin errs++; $display("FAIL reset_alarm got %b want 0", alarma); end
    step(L); step(S); step(T); set_ini(24'h000007); step(L);
    checks++; if (alarma !== 1'b0) begin errs++; $display("FAIL load_in_alarm got %b want 0", alarma); end
    checks++; if (cnt !== 24'h000007) begin errs++; $display("FAIL load_in_alarm_count got %h want 000007", cnt); end
    checks++; if (running !== 1'b0) begin errs++; $display("FAIL load_in_alarm_running got %b want 0", running); end
  endtask
  task automatic test_autoreload;
    set_ini(24'h000002); step(L); step(S); step(T); step(T);
    exp_cnt = AR ? 24'h000002 : 24'h0;
    checks++; if (alarma !== 1'b1) begin errs++; $display("FAIL reload_alarma got %b want 1", alarma); end
    checks++; if (cnt !== exp_cnt) begin errs++; $display("FAIL reload_count got %h want %h", cnt, exp_cnt); end
    step(A);
    checks++; if (running !== AR) begin errs++; $display("FAIL reload_ack_running got %b want %b", running, AR); end
    step(T);
    exp_cnt = AR ? 24'h000001 : 24'h0;
    checks++; if (cnt !== exp_cnt) begin errs++; $display("FAIL reload_tick got %h want %h", cnt, exp_cnt); end
  endtask
  initial begin
    step(R);
    test_reset;
    test_countdown;
    test_borrow;
    test_load_err;
    test_pause;
    test_reset_mid;
    test_autoreload;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
